sirv_icb2to1_arbt: RTL and testbench

//  2-master to 1-slave ICB arbiter; sits directly upstream of the 1-to-2 bus fab and feeds its i_icb port.

---
 rtl/sirv_icb2to1_arbt.sv | 217 +++++++++++++++++++++
 tb/tb_sirv_icb2to1_arbt.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_icb2to1_arbt.sv
// rtl/sirv_icb2to1_arbt.sv - 2-master to 1-slave ICB arbiter with round-robin grant and in-order response routing
// Optional bus lock support: define SIRV_ICB2TO1_LOCK_EN.
module sirv_icb2to1_arbt #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int OUTS_NUM = 2,
  parameter int OUTS_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i0_icb_cmd_valid,
  output logic              i0_icb_cmd_ready,
  input  logic [AW-1:0]     i0_icb_cmd_addr,
  input  logic              i0_icb_cmd_read,
  input  logic [DW-1:0]     i0_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i0_icb_cmd_wmask,
  input  logic              i0_icb_cmd_lock,
  input  logic              i0_icb_cmd_excl,
  input  logic [1:0]        i0_icb_cmd_size,
  input  logic [1:0]        i0_icb_cmd_burst,
  input  logic [1:0]        i0_icb_cmd_beat,
  output logic              i0_icb_rsp_valid,
  input  logic              i0_icb_rsp_ready,
  output logic              i0_icb_rsp_err,
  output logic              i0_icb_rsp_excl_ok,
  output logic [DW-1:0]     i0_icb_rsp_rdata,

  input  logic              i1_icb_cmd_valid,
  output logic              i1_icb_cmd_ready,
  input  logic [AW-1:0]     i1_icb_cmd_addr,
  input  logic              i1_icb_cmd_read,
  input  logic [DW-1:0]     i1_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i1_icb_cmd_wmask,
  input  logic              i1_icb_cmd_lock,
  input  logic              i1_icb_cmd_excl,
  input  logic [1:0]        i1_icb_cmd_size,
  input  logic [1:0]        i1_icb_cmd_burst,
  input  logic [1:0]        i1_icb_cmd_beat,
  output logic              i1_icb_rsp_valid,
  input  logic              i1_icb_rsp_ready,
  output logic              i1_icb_rsp_err,
  output logic              i1_icb_rsp_excl_ok,
  output logic [DW-1:0]     i1_icb_rsp_rdata,

  output logic              o_icb_cmd_valid,
  input  logic              o_icb_cmd_ready,
  output logic [AW-1:0]     o_icb_cmd_addr,
  output logic              o_icb_cmd_read,
  output logic [DW-1:0]     o_icb_cmd_wdata,
  output logic [DW/8-1:0]   o_icb_cmd_wmask,
  output logic              o_icb_cmd_lock,
  output logic              o_icb_cmd_excl,
  output logic [1:0]        o_icb_cmd_size,
  output logic [1:0]        o_icb_cmd_burst,
  output logic [1:0]        o_icb_cmd_beat,
  input  logic              o_icb_rsp_valid,
  output logic              o_icb_rsp_ready,
  input  logic              o_icb_rsp_err,
  input  logic              o_icb_rsp_excl_ok,
  input  logic [DW-1:0]     o_icb_rsp_rdata
);

  // Counter must be able to hold OUTS_NUM itself, so never narrower than clog2(OUTS_NUM+1).
  localparam int CNT_W = (OUTS_W > $clog2(OUTS_NUM + 1)) ? OUTS_W : $clog2(OUTS_NUM + 1);
  localparam int PTR_W = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTS_NUM);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTS_NUM - 1);

  logic                 rr_ptr_q, rr_ptr_d;
  logic                 hold_q, hold_d;
  logic                 hold_id_q, hold_id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [OUTS_NUM-1:0]  mem_q, mem_d;

  logic sel;
  logic req_sel;
  logic full;
  logic empty;
  logic cmd_hs;
  logic rsp_hs;
  logic head_id;

`ifdef SIRV_ICB2TO1_LOCK_EN
  logic lock_vld_q, lock_vld_d;
  logic lock_own_q, lock_own_d;
`endif

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign head_id = mem_q[rptr_q];

  // Held grant beats lock ownership beats round-robin.
  always_comb begin
    sel = 1'b0;
    if (hold_q) begin
      sel = hold_id_q;
    end
`ifdef SIRV_ICB2TO1_LOCK_EN
    else if (lock_vld_q) begin
      sel = lock_own_q;
    end
`endif
    else if (i0_icb_cmd_valid && i1_icb_cmd_valid) begin
      sel = rr_ptr_q;
    end else if (i1_icb_cmd_valid) begin
      sel = 1'b1;
    end
  end

  assign req_sel          = sel ? i1_icb_cmd_valid : i0_icb_cmd_valid;
  assign o_icb_cmd_valid  = req_sel & ~full;
  assign i0_icb_cmd_ready = ~sel & i0_icb_cmd_valid & o_icb_cmd_ready & ~full;
  assign i1_icb_cmd_ready =  sel & i1_icb_cmd_valid & o_icb_cmd_ready & ~full;
  assign cmd_hs           = o_icb_cmd_valid & o_icb_cmd_ready;

  assign o_icb_cmd_addr  = sel ? i1_icb_cmd_addr  : i0_icb_cmd_addr;
  assign o_icb_cmd_read  = sel ? i1_icb_cmd_read  : i0_icb_cmd_read;
  assign o_icb_cmd_wdata = sel ? i1_icb_cmd_wdata : i0_icb_cmd_wdata;
  assign o_icb_cmd_wmask = sel ? i1_icb_cmd_wmask : i0_icb_cmd_wmask;
  assign o_icb_cmd_lock  = sel ? i1_icb_cmd_lock  : i0_icb_cmd_lock;
  assign o_icb_cmd_excl  = sel ? i1_icb_cmd_excl  : i0_icb_cmd_excl;
  assign o_icb_cmd_size  = sel ? i1_icb_cmd_size  : i0_icb_cmd_size;
  assign o_icb_cmd_burst = sel ? i1_icb_cmd_burst : i0_icb_cmd_burst;
  assign o_icb_cmd_beat  = sel ? i1_icb_cmd_beat  : i0_icb_cmd_beat;

  assign i0_icb_rsp_valid = o_icb_rsp_valid & ~empty & ~head_id;
  assign i1_icb_rsp_valid = o_icb_rsp_valid & ~empty &  head_id;
  assign o_icb_rsp_ready  = ~empty & (head_id ? i1_icb_rsp_ready : i0_icb_rsp_ready);
  assign rsp_hs           = o_icb_rsp_valid & o_icb_rsp_ready;

  assign i0_icb_rsp_err     = o_icb_rsp_err;
  assign i0_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
  assign i0_icb_rsp_rdata   = o_icb_rsp_rdata;
  assign i1_icb_rsp_err     = o_icb_rsp_err;
  assign i1_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
  assign i1_icb_rsp_rdata   = o_icb_rsp_rdata;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    if (cmd_hs) begin
      hold_d   = 1'b0;
      rr_ptr_d = ~sel;
    end else if (o_icb_cmd_valid) begin
      hold_d    = 1'b1;
      hold_id_d = sel;
    end
  end

`ifdef SIRV_ICB2TO1_LOCK_EN
  // Only the owner can handshake while locked, so a lock=0 handshake always releases.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (cmd_hs) begin
      lock_vld_d = o_icb_cmd_lock;
      if (o_icb_cmd_lock) begin
        lock_own_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (cmd_hs) begin
      mem_d[wptr_q] = sel;
      wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (rsp_hs) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    case ({cmd_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= 1'b0;
      hold_q    <= 1'b0;
      hold_id_q <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      mem_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_sirv_icb2to1_arbt.sv
// tb/tb_sirv_icb2to1_arbt.sv - self-checking bench for sirv_icb2to1_arbt
module tb_sirv_icb2to1_arbt;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i0_icb_cmd_valid, i0_icb_cmd_ready, i0_icb_cmd_read, i0_icb_cmd_lock, i0_icb_cmd_excl;
  logic [31:0] i0_icb_cmd_addr, i0_icb_cmd_wdata;
  logic [3:0]  i0_icb_cmd_wmask;
  logic [1:0]  i0_icb_cmd_size, i0_icb_cmd_burst, i0_icb_cmd_beat;
  logic        i0_icb_rsp_valid, i0_icb_rsp_ready, i0_icb_rsp_err, i0_icb_rsp_excl_ok;
  logic [31:0] i0_icb_rsp_rdata;
  logic        i1_icb_cmd_valid, i1_icb_cmd_ready, i1_icb_cmd_read, i1_icb_cmd_lock, i1_icb_cmd_excl;
  logic [31:0] i1_icb_cmd_addr, i1_icb_cmd_wdata;
  logic [3:0]  i1_icb_cmd_wmask;
  logic [1:0]  i1_icb_cmd_size, i1_icb_cmd_burst, i1_icb_cmd_beat;
  logic        i1_icb_rsp_valid, i1_icb_rsp_ready, i1_icb_rsp_err, i1_icb_rsp_excl_ok;
  logic [31:0] i1_icb_rsp_rdata;
  logic        o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read, o_icb_cmd_lock, o_icb_cmd_excl;
  logic [31:0] o_icb_cmd_addr, o_icb_cmd_wdata;
  logic [3:0]  o_icb_cmd_wmask;
  logic [1:0]  o_icb_cmd_size, o_icb_cmd_burst, o_icb_cmd_beat;
  logic        o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err, o_icb_rsp_excl_ok;
  logic [31:0] o_icb_rsp_rdata;

  int checks = 0;
  int errors = 0;

  sirv_icb2to1_arbt #(.AW(32), .DW(32), .OUTS_NUM(2), .OUTS_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_icb_cmd_valid(i0_icb_cmd_valid), .i0_icb_cmd_ready(i0_icb_cmd_ready),
    .i0_icb_cmd_addr(i0_icb_cmd_addr), .i0_icb_cmd_read(i0_icb_cmd_read),
    .i0_icb_cmd_wdata(i0_icb_cmd_wdata), .i0_icb_cmd_wmask(i0_icb_cmd_wmask),
    .i0_icb_cmd_lock(i0_icb_cmd_lock), .i0_icb_cmd_excl(i0_icb_cmd_excl),
    .i0_icb_cmd_size(i0_icb_cmd_size), .i0_icb_cmd_burst(i0_icb_cmd_burst),
    .i0_icb_cmd_beat(i0_icb_cmd_beat),
    .i0_icb_rsp_valid(i0_icb_rsp_valid), .i0_icb_rsp_ready(i0_icb_rsp_ready),
    .i0_icb_rsp_err(i0_icb_rsp_err), .i0_icb_rsp_excl_ok(i0_icb_rsp_excl_ok),
    .i0_icb_rsp_rdata(i0_icb_rsp_rdata),
    .i1_icb_cmd_valid(i1_icb_cmd_valid), .i1_icb_cmd_ready(i1_icb_cmd_ready),
    .i1_icb_cmd_addr(i1_icb_cmd_addr), .i1_icb_cmd_read(i1_icb_cmd_read),
    .i1_icb_cmd_wdata(i1_icb_cmd_wdata), .i1_icb_cmd_wmask(i1_icb_cmd_wmask),
    .i1_icb_cmd_lock(i1_icb_cmd_lock), .i1_icb_cmd_excl(i1_icb_cmd_excl),
    .i1_icb_cmd_size(i1_icb_cmd_size), .i1_icb_cmd_burst(i1_icb_cmd_burst),
    .i1_icb_cmd_beat(i1_icb_cmd_beat),
    .i1_icb_rsp_valid(i1_icb_rsp_valid), .i1_icb_rsp_ready(i1_icb_rsp_ready),
    .i1_icb_rsp_err(i1_icb_rsp_err), .i1_icb_rsp_excl_ok(i1_icb_rsp_excl_ok),
    .i1_icb_rsp_rdata(i1_icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_cmd_lock(o_icb_cmd_lock), .o_icb_cmd_excl(o_icb_cmd_excl),
    .o_icb_cmd_size(o_icb_cmd_size), .o_icb_cmd_burst(o_icb_cmd_burst),
    .o_icb_cmd_beat(o_icb_cmd_beat),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_excl_ok(o_icb_rsp_excl_ok),
    .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  task automatic clear_inputs();
    i0_icb_cmd_valid = 0; i0_icb_cmd_addr = 0; i0_icb_cmd_read = 0; i0_icb_cmd_wdata = 0;
    i0_icb_cmd_wmask = 0; i0_icb_cmd_lock = 0; i0_icb_cmd_excl = 0; i0_icb_cmd_size = 0;
    i0_icb_cmd_burst = 0; i0_icb_cmd_beat = 0; i0_icb_rsp_ready = 0;
    i1_icb_cmd_valid = 0; i1_icb_cmd_addr = 0; i1_icb_cmd_read = 0; i1_icb_cmd_wdata = 0;
    i1_icb_cmd_wmask = 0; i1_icb_cmd_lock = 0; i1_icb_cmd_excl = 0; i1_icb_cmd_size = 0;
    i1_icb_cmd_burst = 0; i1_icb_cmd_beat = 0; i1_icb_rsp_ready = 0;
    o_icb_cmd_ready = 0; o_icb_rsp_valid = 0; o_icb_rsp_err = 0; o_icb_rsp_excl_ok = 0;
    o_icb_rsp_rdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    o_icb_cmd_ready = 1;
    i0_icb_rsp_ready = 1;
    i1_icb_rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_o_cmd_valid got %b exp 0", o_icb_cmd_valid); end
    checks++; if ({i0_icb_cmd_ready, i1_icb_cmd_ready} !== 2'b00) begin errors++; $display("FAIL reset_cmd_ready got %b exp 00", {i0_icb_cmd_ready, i1_icb_cmd_ready}); end
    o_icb_rsp_valid = 1; #1;
    checks++; if (o_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_o_rsp_ready got %b exp 0", o_icb_rsp_ready); end
    checks++; if ({i0_icb_rsp_valid, i1_icb_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", {i0_icb_rsp_valid, i1_icb_rsp_valid}); end
    rst_n = 1;
  endtask

  task automatic test_alternate();
    int g;
    do_reset();
    i0_icb_cmd_valid = 1; i1_icb_cmd_valid = 1; o_icb_cmd_ready = 1;
    i0_icb_rsp_ready = 1; i1_icb_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      i0_icb_cmd_addr = 32'h1000 + k; i1_icb_cmd_addr = 32'h2000 + k;
      o_icb_rsp_valid = (k > 0); o_icb_rsp_rdata = 32'hA000 + k;
      #1;
      g = k % 2;
      checks++; if (o_icb_cmd_addr !== ((g == 1) ? 32'h2000 + k : 32'h1000 + k)) begin errors++; $display("FAIL alt_addr k=%0d got %h exp grant i%0d", k, o_icb_cmd_addr, g); end
      checks++; if ({i1_icb_cmd_ready, i0_icb_cmd_ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_ready k=%0d got %b exp grant i%0d", k, {i1_icb_cmd_ready, i0_icb_cmd_ready}, g); end
      if (k > 0) begin
        checks++; if ({i1_icb_rsp_valid, i0_icb_rsp_valid} !== (((k - 1) % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_rsp k=%0d got %b", k, {i1_icb_rsp_valid, i0_icb_rsp_valid}); end
      end
      step();
    end
  endtask

  task automatic test_hold();
    do_reset();
    i0_icb_rsp_ready = 1; i1_icb_rsp_ready = 1;
    i0_icb_cmd_valid = 1; i0_icb_cmd_addr = 32'h10; o_icb_cmd_ready = 1; #1;
    checks++; if (i0_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_first got %b exp 1", i0_icb_cmd_ready); end
    step();
    i0_icb_cmd_addr = 32'h11; o_icb_cmd_ready = 0; o_icb_rsp_valid = 1; #1;
    checks++; if (i0_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_rsp got %b exp 1", i0_icb_rsp_valid); end
    step();
    o_icb_rsp_valid = 0;
    for (int j = 0; j < 2; j++) begin
      i1_icb_cmd_valid = 1; i1_icb_cmd_addr = 32'h20; #1;
      checks++; if (o_icb_cmd_addr !== 32'h11 || o_icb_cmd_valid !== 1'b1) begin errors++; $display("FAIL hold_keep j=%0d got %h v=%b exp 00000011", j, o_icb_cmd_addr, o_icb_cmd_valid); end
      step();
    end
    o_icb_cmd_ready = 1; #1;
    checks++; if ({i1_icb_cmd_ready, i0_icb_cmd_ready} !== 2'b01) begin errors++; $display("FAIL hold_release got %b exp 01", {i1_icb_cmd_ready, i0_icb_cmd_ready}); end
    step();
    i0_icb_cmd_valid = 0; #1;
    checks++; if (i1_icb_cmd_ready !== 1'b1 || o_icb_cmd_addr !== 32'h20) begin errors++; $display("FAIL hold_next got %b %h exp 1 00000020", i1_icb_cmd_ready, o_icb_cmd_addr); end
    step();
  endtask

  task automatic test_full();
    do_reset();
    i0_icb_cmd_valid = 1; o_icb_cmd_ready = 1; i0_icb_rsp_ready = 1;
    for (int k = 0; k < 2; k++) begin
      i0_icb_cmd_addr = 32'h100 + k; #1;
      checks++; if (i0_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL full_fill k=%0d got %b exp 1", k, i0_icb_cmd_ready); end
      step();
    end
    i0_icb_cmd_addr = 32'h102; #1;
    checks++; if ({o_icb_cmd_valid, i0_icb_cmd_ready} !== 2'b00) begin errors++; $display("FAIL full_block got %b exp 00", {o_icb_cmd_valid, i0_icb_cmd_ready}); end
    step();
    o_icb_rsp_valid = 1; #1;
    checks++; if (o_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", o_icb_rsp_ready); end
    checks++; if (o_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %b exp 0", o_icb_cmd_valid); end
    step();
    o_icb_rsp_valid = 0; #1;
    checks++; if ({o_icb_cmd_valid, i0_icb_cmd_ready} !== 2'b11 || o_icb_cmd_addr !== 32'h102) begin errors++; $display("FAIL full_resume got %b %h exp 11 00000102", {o_icb_cmd_valid, i0_icb_cmd_ready}, o_icb_cmd_addr); end
    step();
  endtask

  task automatic test_rsp_route();
    do_reset();
    i1_icb_cmd_valid = 1; o_icb_cmd_ready = 1; #1;
    checks++; if (i1_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL route_cmd got %b exp 1", i1_icb_cmd_ready); end
    step();
    i1_icb_cmd_valid = 0; o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'hDEADBEEF;
    i0_icb_rsp_ready = 1; i1_icb_rsp_ready = 0; #1;
    checks++; if (o_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL route_stall got %b exp 0", o_icb_rsp_ready); end
    checks++; if ({i1_icb_rsp_valid, i0_icb_rsp_valid} !== 2'b10) begin errors++; $display("FAIL route_target got %b exp 10", {i1_icb_rsp_valid, i0_icb_rsp_valid}); end
    step();
    i1_icb_rsp_ready = 1; #1;
    checks++; if (o_icb_rsp_ready !== 1'b1 || i1_icb_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL route_deliver got %b %h exp 1 deadbeef", o_icb_rsp_ready, i1_icb_rsp_rdata); end
    step();
    #1;
    checks++; if ({o_icb_rsp_ready, i1_icb_rsp_valid, i0_icb_rsp_valid} !== 3'b000) begin errors++; $display("FAIL route_empty got %b exp 000", {o_icb_rsp_ready, i1_icb_rsp_valid, i0_icb_rsp_valid}); end
    o_icb_rsp_valid = 0;
  endtask

  task automatic test_push_pop();
    do_reset();
    i0_icb_rsp_ready = 1; i1_icb_rsp_ready = 1; o_icb_cmd_ready = 1;
    i0_icb_cmd_valid = 1; #1;
    step();
    i0_icb_cmd_valid = 0; i1_icb_cmd_valid = 1; o_icb_rsp_valid = 1; #1;
    checks++; if ({i1_icb_cmd_ready, i0_icb_rsp_valid, o_icb_rsp_ready} !== 3'b111) begin errors++; $display("FAIL pp_both got %b exp 111", {i1_icb_cmd_ready, i0_icb_rsp_valid, o_icb_rsp_ready}); end
    step();
    i1_icb_cmd_valid = 0; i0_icb_cmd_valid = 1; o_icb_rsp_valid = 0; #1;
    checks++; if (i0_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL pp_cnt_one got %b exp 1", i0_icb_cmd_ready); end
    step();
    o_icb_rsp_valid = 1; #1;
    checks++; if (i0_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL pp_cnt_full got %b exp 0", i0_icb_cmd_ready); end
    checks++; if ({i1_icb_rsp_valid, i0_icb_rsp_valid} !== 2'b10) begin errors++; $display("FAIL pp_order got %b exp 10", {i1_icb_rsp_valid, i0_icb_rsp_valid}); end
    step();
  endtask

  task automatic test_lock();
    int n0;
    int exp_g;
    do_reset();
    n0 = 0;
    i0_icb_cmd_valid = 1; i1_icb_cmd_valid = 1; o_icb_cmd_ready = 1;
    i0_icb_rsp_ready = 1; i1_icb_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      i0_icb_cmd_lock = (n0 < 2);
      o_icb_rsp_valid = (k > 0);
      #1;
`ifdef SIRV_ICB2TO1_LOCK_EN
      exp_g = (k < 3) ? 0 : 1;
`else
      exp_g = k % 2;
`endif
      checks++; if ({i1_icb_cmd_ready, i0_icb_cmd_ready} !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lock_grant k=%0d got %b exp i%0d", k, {i1_icb_cmd_ready, i0_icb_cmd_ready}, exp_g); end
      if (i0_icb_cmd_ready) n0++;
      step();
    end
  endtask

  task automatic test_random();
    int q[$];
    bit pend[2];
    bit lk[2];
    bit rr[2];
    logic [31:0] ad[2];
    logic [31:0] wd[2];
    int pref, held, lock_own, w, head;
    bit full, ev, orr;
    do_reset();
    pref = 0; held = -1; lock_own = -1;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) != 0) begin
          pend[m] = 1; ad[m] = $urandom; wd[m] = $urandom; lk[m] = ($urandom_range(0, 5) == 0);
        end
        rr[m] = $urandom_range(0, 3) != 0;
      end
      i0_icb_cmd_valid = pend[0]; i0_icb_cmd_addr = ad[0]; i0_icb_cmd_wdata = wd[0]; i0_icb_cmd_lock = lk[0];
      i1_icb_cmd_valid = pend[1]; i1_icb_cmd_addr = ad[1]; i1_icb_cmd_wdata = wd[1]; i1_icb_cmd_lock = lk[1];
      i0_icb_rsp_ready = rr[0]; i1_icb_rsp_ready = rr[1];
      o_icb_cmd_ready = $urandom_range(0, 3) != 0;
      o_icb_rsp_valid = $urandom_range(0, 1);
      o_icb_rsp_rdata = $urandom;
      #1;
      full = (q.size() >= 2);
      if (held >= 0) w = held;
`ifdef SIRV_ICB2TO1_LOCK_EN
      else if (lock_own >= 0) w = lock_own;
`endif
      else if (pend[0] && pend[1]) w = pref;
      else w = (pend[1] && !pend[0]) ? 1 : 0;
      ev = pend[w] && !full;
      head = (q.size() > 0) ? q[0] : -1;
      orr = (head >= 0) && rr[head];
      checks++; if (o_icb_cmd_valid !== ev) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, o_icb_cmd_valid, ev); end
      if (ev) begin
        checks++; if (o_icb_cmd_addr !== ad[w] || o_icb_cmd_wdata !== wd[w] || o_icb_cmd_lock !== lk[w]) begin errors++; $display("FAIL rnd_payload c=%0d got %h exp %h (i%0d)", c, o_icb_cmd_addr, ad[w], w); end
      end
      checks++; if (i0_icb_cmd_ready !== (ev && w == 0 && o_icb_cmd_ready)) begin errors++; $display("FAIL rnd_i0_ready c=%0d got %b", c, i0_icb_cmd_ready); end
      checks++; if (i1_icb_cmd_ready !== (ev && w == 1 && o_icb_cmd_ready)) begin errors++; $display("FAIL rnd_i1_ready c=%0d got %b", c, i1_icb_cmd_ready); end
      checks++; if (o_icb_rsp_ready !== orr) begin errors++; $display("FAIL rnd_rsp_ready c=%0d got %b exp %b", c, o_icb_rsp_ready, orr); end
      checks++; if ({i1_icb_rsp_valid, i0_icb_rsp_valid} !== {o_icb_rsp_valid && head == 1, o_icb_rsp_valid && head == 0}) begin errors++; $display("FAIL rnd_rsp_valid c=%0d got %b head %0d", c, {i1_icb_rsp_valid, i0_icb_rsp_valid}, head); end
      checks++; if (i0_icb_rsp_rdata !== o_icb_rsp_rdata || i1_icb_rsp_rdata !== o_icb_rsp_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d", c); end
      if (o_icb_rsp_valid && orr) void'(q.pop_front());
      if (ev && o_icb_cmd_ready) begin
        q.push_back(w); pref = 1 - w; held = -1; pend[w] = 0;
        lock_own = lk[w] ? w : -1;
      end else if (ev) begin
        held = w;
      end
      step();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_alternate();
    test_hold();
    test_full();
    test_rsp_route();
    test_push_pop();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
